// File: rtl/gol_grid_ram_fill.sv
// Dual-port Game of Life grid RAM (A: read, B: read/write) with a one-cell-per-cycle bulk-fill sequencer.
// Define GOL_RAM_OUTREG_EN to add an output register stage on both ports (read latency 2).
module gol_grid_ram_fill #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_a,
    input  logic [ADDR_W-1:0] addr_a,
    output logic [DATA_W-1:0] dout_a,
    output logic              vld_a,
    input  logic              en_b,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] din_b,
    output logic [DATA_W-1:0] dout_b,
    output logic              vld_b,
    input  logic              fill_start,
    input  logic [DATA_W-1:0] fill_value,
    output logic              fill_busy,
    output logic              fill_done
);

    localparam int                DEPTH     = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_CELL = {ADDR_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]   fval_q, fval_d;
    logic                fill_we;
    logic                user_ok;

    logic [DATA_W-1:0]   mem [DEPTH];
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [DATA_W-1:0]   mem_wdata;

    logic [DATA_W-1:0]   rda_q, rdb_q;
    logic                va_q, vb_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            fval_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fval_q  <= fval_d;
        end
    end

    // Terminal compare on the last cell: the counter may wrap, but the FSM has already left FILL.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fval_d  = fval_q;
        case (state_q)
            IDLE: begin
                if (fill_start) begin
                    state_d = FILL;
                    cnt_d   = '0;
                    fval_d  = fill_value;
                end
            end
            FILL: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_CELL) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        fill_busy = 1'b0;
        fill_done = 1'b0;
        fill_we   = 1'b0;
        user_ok   = 1'b0;
        case (state_q)
            IDLE: user_ok = 1'b1;
            FILL: begin
                fill_busy = 1'b1;
                fill_we   = 1'b1;
            end
            DONE:    fill_done = 1'b1;
            default: user_ok   = 1'b0;
        endcase
    end

    // Single write port shared between the fill sequencer and the engine side.
    assign mem_we    = fill_we | (user_ok & en_b & we_b);
    assign mem_waddr = fill_we ? cnt_q  : addr_b;
    assign mem_wdata = fill_we ? fval_q : din_b;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Port A sees pre-write contents on a same-address collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rda_q <= '0;
            va_q  <= 1'b0;
        end else begin
            va_q <= en_a;
            if (en_a) begin
                rda_q <= mem[addr_a];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdb_q <= '0;
            vb_q  <= 1'b0;
        end else begin
            vb_q <= user_ok & en_b;
            if (user_ok && en_b) begin
                rdb_q <= we_b ? din_b : mem[addr_b];
            end
        end
    end

`ifdef GOL_RAM_OUTREG_EN
    logic [DATA_W-1:0] oa_q, ob_q;
    logic              ova_q, ovb_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oa_q  <= '0;
            ob_q  <= '0;
            ova_q <= 1'b0;
            ovb_q <= 1'b0;
        end else begin
            oa_q  <= rda_q;
            ob_q  <= rdb_q;
            ova_q <= va_q;
            ovb_q <= vb_q;
        end
    end

    assign dout_a = oa_q;
    assign dout_b = ob_q;
    assign vld_a  = ova_q;
    assign vld_b  = ovb_q;
`else
    assign dout_a = rda_q;
    assign dout_b = rdb_q;
    assign vld_a  = va_q;
    assign vld_b  = vb_q;
`endif

endmodule

// File: tb/tb_gol_grid_ram_fill.sv
// Bench for gol_grid_ram_fill: a 16-bit-address instance for port behaviour, a 4-bit one for fill sequencing.
module tb_gol_grid_ram_fill;

`ifdef GOL_RAM_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Wide instance (suffix _h)
    logic        en_a_h = 0, en_b_h = 0, we_b_h = 0, fs_h = 0;
    logic [15:0] addr_a_h = 0, addr_b_h = 0;
    logic [3:0]  din_b_h = 0, fv_h = 0, dout_a_h, dout_b_h;
    logic        vld_a_h, vld_b_h, busy_h, done_h;

    // Small instance (suffix _s)
    logic        en_a_s = 0, en_b_s = 0, we_b_s = 0, fs_s = 0;
    logic [3:0]  addr_a_s = 0, addr_b_s = 0;
    logic [3:0]  din_b_s = 0, fv_s = 0, dout_a_s, dout_b_s;
    logic        vld_a_s, vld_b_s, busy_s, done_s;

    gol_grid_ram_fill #(.DATA_W(4), .ADDR_W(16)) u_big (
        .clk(clk), .rst_n(rst_n),
        .en_a(en_a_h), .addr_a(addr_a_h), .dout_a(dout_a_h), .vld_a(vld_a_h),
        .en_b(en_b_h), .we_b(we_b_h), .addr_b(addr_b_h), .din_b(din_b_h),
        .dout_b(dout_b_h), .vld_b(vld_b_h),
        .fill_start(fs_h), .fill_value(fv_h), .fill_busy(busy_h), .fill_done(done_h)
    );

    gol_grid_ram_fill #(.DATA_W(4), .ADDR_W(4)) u_small (
        .clk(clk), .rst_n(rst_n),
        .en_a(en_a_s), .addr_a(addr_a_s), .dout_a(dout_a_s), .vld_a(vld_a_s),
        .en_b(en_b_s), .we_b(we_b_s), .addr_b(addr_b_s), .din_b(din_b_s),
        .dout_b(dout_b_s), .vld_b(vld_b_s),
        .fill_start(fs_s), .fill_value(fv_s), .fill_busy(busy_s), .fill_done(done_s)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    endtask

    typedef struct {
        logic [3:0] d;
        int         due;
    } sb_t;

    sb_t qa_h[$], qb_h[$], qa_s[$], qb_s[$];

    always @(negedge clk) begin
        sb_t it;
        if (rst_n && vld_a_h) begin
            if (qa_h.size() == 0) chk("a16_spurious_vld", vld_a_h, 0);
            else begin
                it = qa_h.pop_front();
                $display("a16 read  data=%h exp=%h cyc=%0d", dout_a_h, it.d, cyc);
                chk("a16_data", dout_a_h, it.d);
                chk("a16_latency", cyc, it.due);
            end
        end
        if (rst_n && vld_b_h) begin
            if (qb_h.size() == 0) chk("b16_spurious_vld", vld_b_h, 0);
            else begin
                it = qb_h.pop_front();
                $display("b16 access data=%h exp=%h cyc=%0d", dout_b_h, it.d, cyc);
                chk("b16_data", dout_b_h, it.d);
                chk("b16_latency", cyc, it.due);
            end
        end
        if (rst_n && vld_a_s) begin
            if (qa_s.size() == 0) chk("a4_spurious_vld", vld_a_s, 0);
            else begin
                it = qa_s.pop_front();
                $display("a4 read  data=%h exp=%h cyc=%0d", dout_a_s, it.d, cyc);
                chk("a4_data", dout_a_s, it.d);
                chk("a4_latency", cyc, it.due);
            end
        end
        if (rst_n && vld_b_s) begin
            if (qb_s.size() == 0) chk("b4_spurious_vld", vld_b_s, 0);
            else begin
                it = qb_s.pop_front();
                $display("b4 access data=%h exp=%h cyc=%0d", dout_b_s, it.d, cyc);
                chk("b4_data", dout_b_s, it.d);
                chk("b4_latency", cyc, it.due);
            end
        end
    end

    typedef struct {
        logic        en_a;
        logic [15:0] addr_a;
        logic        en_b;
        logic        we_b;
        logic [15:0] addr_b;
        logic [3:0]  din_b;
        logic [3:0]  exp_a;
        logic [3:0]  exp_b;
    } vec_t;

    vec_t vt[11];

    task automatic read_all_small(input logic [3:0] lo_val, input logic [3:0] hi_val, input int split);
        for (int i = 0; i < 16; i++) begin
            en_a_s   = 1'b1;
            addr_a_s = 4'(i);
            qa_s.push_back('{(i < split) ? lo_val : hi_val, cyc + LAT});
            @(negedge clk);
        end
        en_a_s = 1'b0;
        repeat (LAT + 2) @(negedge clk);
        chk("a4_queue_drained", qa_s.size(), 0);
    endtask

    initial begin
        int bc, dc, last_busy, done_idx, vldb_seen, found;

        vt[0]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0010, 4'h5, 4'h0, 4'h5};
        vt[1]  = '{1'b1, 16'h0010, 1'b0, 1'b0, 16'h0000, 4'h0, 4'h5, 4'h0};
        vt[2]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h1234, 4'hA, 4'h0, 4'hA};
        vt[3]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h1234, 4'h0, 4'h0, 4'hA};
        vt[4]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0042, 4'h3, 4'h0, 4'h3};
        vt[5]  = '{1'b1, 16'h0042, 1'b1, 1'b1, 16'h0042, 4'hC, 4'h3, 4'hC};
        vt[6]  = '{1'b1, 16'h0042, 1'b0, 1'b0, 16'h0000, 4'h0, 4'hC, 4'h0};
        vt[7]  = '{1'b1, 16'h1234, 1'b1, 1'b0, 16'h0010, 4'h0, 4'hA, 4'h5};
        vt[8]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 4'h9, 4'h0, 4'h9};
        vt[9]  = '{1'b1, 16'hFFFF, 1'b1, 1'b1, 16'h0000, 4'h1, 4'h9, 4'h1};
        vt[10] = '{1'b1, 16'h0000, 1'b0, 1'b0, 16'h0000, 4'h0, 4'h1, 4'h0};

        // Reset state
        #12;
        chk("rst_dout_a", dout_a_h, 0);
        chk("rst_dout_b", dout_b_h, 0);
        chk("rst_vld_a", vld_a_h, 0);
        chk("rst_vld_b", vld_b_h, 0);
        chk("rst_busy", busy_s, 0);
        chk("rst_done", done_s, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Port A/B behaviour on the wide instance
        for (int i = 0; i < 11; i++) begin
            en_a_h = vt[i].en_a; addr_a_h = vt[i].addr_a;
            en_b_h = vt[i].en_b; we_b_h = vt[i].we_b;
            addr_b_h = vt[i].addr_b; din_b_h = vt[i].din_b;
            if (vt[i].en_a) qa_h.push_back('{vt[i].exp_a, cyc + LAT});
            if (vt[i].en_b) qb_h.push_back('{vt[i].exp_b, cyc + LAT});
            @(negedge clk);
        end
        en_a_h = 0; en_b_h = 0; we_b_h = 0;
        repeat (LAT + 2) @(negedge clk);
        chk("a16_queue_drained", qa_h.size(), 0);
        chk("b16_queue_drained", qb_h.size(), 0);
        chk("a16_hold_dout", dout_a_h, 4'h1);
        chk("a16_idle_vld", vld_a_h, 0);

        // Known dout_b before fill
        en_b_s = 1; we_b_s = 1; addr_b_s = 4'h1; din_b_s = 4'h6;
        qb_s.push_back('{4'h6, cyc + LAT});
        @(negedge clk);
        en_b_s = 0; we_b_s = 0;
        repeat (LAT + 2) @(negedge clk);

        // Fill 0x7 with ignored B writes and a second fill_start
        fs_s = 1; fv_s = 4'h7;
        @(negedge clk);
        fs_s = 0;
        bc = 0; dc = 0; last_busy = -1; done_idx = -1; vldb_seen = 0;
        for (int c = 0; c < 40; c++) begin
            if (busy_s) begin bc++; last_busy = c; end
            if (done_s) begin dc++; if (done_idx < 0) done_idx = c; end
            if (vld_b_s) vldb_seen++;
            if (c >= 2 && c < 10) begin
                en_b_s = 1; we_b_s = 1; addr_b_s = 4'(c - 2); din_b_s = 4'hE;
            end else begin
                en_b_s = 0; we_b_s = 0;
            end
            fs_s = (c == 5); fv_s = (c == 5) ? 4'h2 : 4'h7;
            @(negedge clk);
        end
        fs_s = 0;
        chk("fill7_busy_cycles", bc, 16);
        chk("fill7_done_pulses", dc, 1);
        chk("fill7_done_after_busy", done_idx, last_busy + 1);
        chk("fill7_no_vld_b", vldb_seen, 0);
        chk("fill7_dout_b_hold", dout_b_s, 4'h6);
        chk("b4_queue_drained", qb_s.size(), 0);
        read_all_small(4'h7, 4'h7, 16);

        // Same-cycle user write and fill_start: write completes, fill of 0x0 follows
        en_b_s = 1; we_b_s = 1; addr_b_s = 4'h3; din_b_s = 4'hB;
        fs_s = 1; fv_s = 4'h0;
        qb_s.push_back('{4'hB, cyc + LAT});
        @(negedge clk);
        en_b_s = 0; we_b_s = 0; fs_s = 0;
        found = 0;
        for (int c = 0; c < 40 && found == 0; c++) begin
            if (done_s) found = 1;
            else @(negedge clk);
        end
        chk("fill0_done_seen", found, 1);
        repeat (2) @(negedge clk);

        // Reset while cell 5 is about to be written with 0xF
        fs_s = 1; fv_s = 4'hF;
        @(negedge clk);
        fs_s = 0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy_s, 0);
        chk("midrst_done", done_s, 0);
        chk("midrst_dout_a_s", dout_a_s, 0);
        chk("midrst_dout_a_h", dout_a_h, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("after_rst_busy", busy_s, 0);
        read_all_small(4'hF, 4'h0, 5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
